// File: rtl/core_lsu_ctrl_if.sv
// DCache request/acknowledge bus between the load/store controller and the data cache.
interface core_lsu_ctrl_if;
   logic        oDC_REQ;
   logic        oDC_WE;
   logic [3:0]  oDC_BE;
   logic [31:0] oDC_ADDR;
   logic [31:0] oDC_WDATA;
   logic        iDC_ACK;
   logic [31:0] iDC_RDATA;

   modport master (
      output oDC_REQ, oDC_WE, oDC_BE, oDC_ADDR, oDC_WDATA,
      input  iDC_ACK, iDC_RDATA
   );

   modport slave (
      input  oDC_REQ, oDC_WE, oDC_BE, oDC_ADDR, oDC_WDATA,
      output iDC_ACK, iDC_RDATA
   );
endinterface

// File: rtl/core_lsu_ctrl.sv
// Load/store unit controller: alignment check, DCache handshake with timeout,
// byte-lane steering for stores and lane extraction/extension for loads.
module core_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iValid,
   input  logic                   iRW,
   input  logic [1:0]             iSize,
   input  logic                   iUnsigned,
   input  logic [31:0]            iADDR,
   input  logic [31:0]            iWDATA,
   output logic                   oStall,
   output logic [31:0]            oRDATA,
   output logic                   oDone,
   output logic                   oMisalign,
   output logic                   oBusErr,
   core_lsu_ctrl_if.master        dc
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

   state_t      state, stateNext;
   logic        rwQ, unsQ, misalignQ;
   logic [1:0]  sizeQ;
   logic [31:0] addrQ, wdataQ;
   logic [7:0]  timer;
   logic        aligned, accept, busy, lastCycle;
   logic [3:0]  beMask;
   logic [31:0] wdataLanes, loadVal;
   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      aligned = 1'b0;
      case (iSize)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~iADDR[0];
         2'b10:   aligned = (iADDR[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign accept    = (state == IDLE) && iValid && aligned;
   assign busy      = (state == BUSY);
   assign lastCycle = (timer == 8'(TIMEOUT - 1));

   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= stateNext;
   end

   // Ack is tested before the timer so an ack in the final cycle still completes.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (accept) stateNext = BUSY;
         BUSY: begin
            if (dc.iDC_ACK)     stateNext = DONE;
            else if (lastCycle) stateNext = ERR;
         end
         DONE:    stateNext = IDLE;
         ERR:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      beMask     = 4'b1111;
      wdataLanes = wdataQ;
      case (sizeQ)
         2'b00: begin
            beMask     = 4'b0001 << addrQ[1:0];
            wdataLanes = {4{wdataQ[7:0]}};
         end
         2'b01: begin
            beMask     = addrQ[1] ? 4'b1100 : 4'b0011;
            wdataLanes = {2{wdataQ[15:0]}};
         end
         default: begin
            beMask     = 4'b1111;
            wdataLanes = wdataQ;
         end
      endcase
   end

   always_comb begin
      byteLane = dc.iDC_RDATA[7:0];
      case (addrQ[1:0])
         2'b00:   byteLane = dc.iDC_RDATA[7:0];
         2'b01:   byteLane = dc.iDC_RDATA[15:8];
         2'b10:   byteLane = dc.iDC_RDATA[23:16];
         default: byteLane = dc.iDC_RDATA[31:24];
      endcase
      halfLane = addrQ[1] ? dc.iDC_RDATA[31:16] : dc.iDC_RDATA[15:0];
      loadVal  = dc.iDC_RDATA;
      case (sizeQ)
         2'b00:   loadVal = unsQ ? {24'h0, byteLane} : {{24{byteLane[7]}}, byteLane};
         2'b01:   loadVal = unsQ ? {16'h0, halfLane} : {{16{halfLane[15]}}, halfLane};
         default: loadVal = dc.iDC_RDATA;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rwQ       <= 1'b0;
         unsQ      <= 1'b0;
         sizeQ     <= '0;
         addrQ     <= '0;
         wdataQ    <= '0;
         timer     <= '0;
         oRDATA    <= '0;
         misalignQ <= 1'b0;
      end else begin
         misalignQ <= (state == IDLE) && iValid && !aligned;
         if (accept) begin
            rwQ    <= iRW;
            unsQ   <= iUnsigned;
            sizeQ  <= iSize;
            addrQ  <= iADDR;
            wdataQ <= iWDATA;
            timer  <= '0;
         end else if (busy) begin
            timer <= timer + 8'd1;
            if (dc.iDC_ACK && rwQ) oRDATA <= loadVal;
         end
      end
   end

   assign oStall    = !iRST && (accept || busy);
   assign oDone     = (state == DONE);
   assign oBusErr   = (state == ERR);
   assign oMisalign = misalignQ;

   assign dc.oDC_REQ   = busy;
   assign dc.oDC_WE    = busy && !rwQ;
   assign dc.oDC_BE    = busy ? beMask : '0;
   assign dc.oDC_ADDR  = busy ? {addrQ[31:2], 2'b00} : '0;
   assign dc.oDC_WDATA = busy ? wdataLanes : '0;

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Bench for core_lsu_ctrl: table of requests with hand-derived bus/result values,
// completion pulses scored against a queue, plus a reset-during-busy sequence.
module tb_core_lsu_ctrl;
   localparam int unsigned TO = 16;
   localparam int KD = 0, KM = 1, KE = 2;

   logic        iCLK = 1'b0;
   logic        iRST, iValid, iRW, iUnsigned;
   logic [1:0]  iSize;
   logic [31:0] iADDR, iWDATA, oRDATA;
   logic        oStall, oDone, oMisalign, oBusErr;

   core_lsu_ctrl_if dc();

   core_lsu_ctrl #(.TIMEOUT(TO)) dut (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iRW(iRW), .iSize(iSize),
      .iUnsigned(iUnsigned), .iADDR(iADDR), .iWDATA(iWDATA), .oStall(oStall),
      .oRDATA(oRDATA), .oDone(oDone), .oMisalign(oMisalign), .oBusErr(oBusErr),
      .dc(dc)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic        rw;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ackCyc;
      logic [31:0] rdata;
      int          kind;
      logic [3:0]  be;
      logic [31:0] dcAddr;
      logic [31:0] dcWdata;
      logic [31:0] expRdata;
   } vec_t;

   typedef struct {
      int          kind;
      logic [31:0] rdata;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[$];
   int   nTests = 0, nFail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int ackCyc, input logic [31:0] rdata, input int kind,
                               input logic [3:0] be, input logic [31:0] dcAddr,
                               input logic [31:0] dcWdata, input logic [31:0] expRdata);
      vec_t v;
      v.rw = rw; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.ackCyc = ackCyc; v.rdata = rdata; v.kind = kind; v.be = be;
      v.dcAddr = dcAddr; v.dcWdata = dcWdata; v.expRdata = expRdata;
      return v;
   endfunction

   // Completion monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge iCLK) begin
      if (oDone === 1'b1 || oMisalign === 1'b1 || oBusErr === 1'b1) begin
         chk("pulse_exclusive", 32'(oDone) + 32'(oMisalign) + 32'(oBusErr), 32'd1);
         if (sb.size() == 0) begin
            nTests++;
            nFail++;
            $display("FAIL unexpected_pulse: got done=%b mis=%b err=%b expected none at %0t",
                     oDone, oMisalign, oBusErr, $time);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("pulse_kind", oDone ? 32'd0 : (oMisalign ? 32'd1 : 32'd2), 32'(e.kind));
            chk("rdata", oRDATA, e.rdata);
         end
      end
   end

   task automatic runVec(input vec_t v);
      int unsigned reqCycles = 0;
      bit          ended = 0;
      sb_t         e;
      @(negedge iCLK);
      iValid = 1'b1; iRW = v.rw; iSize = v.size; iUnsigned = v.uns;
      iADDR = v.addr; iWDATA = v.wdata;
      e.kind = v.kind; e.rdata = v.expRdata;
      sb.push_back(e);
      #1 chk("stall_req_cycle", 32'(oStall), (v.kind == KM) ? 32'd0 : 32'd1);
      for (int c = 1; c <= int'(TO) + 4 && !ended; c++) begin
         @(negedge iCLK);
         iValid = 1'b0;
         dc.iDC_ACK = 1'b0;
         if (dc.oDC_REQ === 1'b1) begin
            reqCycles++;
            chk("stall_busy", 32'(oStall), 32'd1);
            chk("dc_be", 32'(dc.oDC_BE), 32'(v.be));
            chk("dc_addr", dc.oDC_ADDR, v.dcAddr);
            chk("dc_wdata", dc.oDC_WDATA, v.dcWdata);
            chk("dc_we", 32'(dc.oDC_WE), 32'(!v.rw));
            if (c == v.ackCyc) begin
               dc.iDC_ACK = 1'b1;
               dc.iDC_RDATA = v.rdata;
            end
         end else begin
            ended = 1;
            chk("stall_after", 32'(oStall), 32'd0);
            if (v.kind != KM) begin
               // New request and stray ack in DONE/ERR must both be ignored.
               iValid = 1'b1;
               dc.iDC_ACK = 1'b1;
               dc.iDC_RDATA = 32'hFFFFFFFF;
               #1 chk("stall_ignored", 32'(oStall), 32'd0);
               @(negedge iCLK);
               iValid = 1'b0;
               dc.iDC_ACK = 1'b0;
               chk("req_after_ignored", 32'(dc.oDC_REQ), 32'd0);
            end
         end
      end
      if (!ended) begin
         nTests++;
         nFail++;
         $display("FAIL req_never_dropped: got still high expected low at %0t", $time);
      end
      chk("req_cycles", reqCycles,
          (v.kind == KD) ? 32'(v.ackCyc) : ((v.kind == KE) ? 32'(TO) : 32'd0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iRST = 1'b1; iValid = 1'b0; iRW = 1'b0; iSize = '0; iUnsigned = 1'b0;
      iADDR = '0; iWDATA = '0; dc.iDC_ACK = 1'b0; dc.iDC_RDATA = '0;
      repeat (3) @(negedge iCLK);
      iRST = 1'b0;
      @(negedge iCLK);
      chk("rst_rdata", oRDATA, 32'h0);
      chk("rst_stall", 32'(oStall), 32'd0);
      chk("rst_req", 32'(dc.oDC_REQ), 32'd0);
      chk("rst_pulses", {29'd0, oDone, oMisalign, oBusErr}, 32'd0);

      vecs.push_back(mk(1, 2'd0, 0, 32'h103, 32'h0,        2,  32'h80AABBCC, KD, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(0, 2'd1, 0, 32'h202, 32'h0000BEEF, 3,  32'h12345678, KD, 4'b1100, 32'h200, 32'hBEEFBEEF, 32'hFFFFFF80));
      vecs.push_back(mk(1, 2'd2, 0, 32'h301, 32'h0,        0,  32'h0,        KM, 4'b0000, 32'h0,   32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(1, 2'd3, 0, 32'h300, 32'h0,        0,  32'h0,        KM, 4'b0000, 32'h0,   32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(1, 2'd1, 1, 32'h002, 32'h0,        0,  32'h0,        KE, 4'b1100, 32'h0,   32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(1, 2'd1, 1, 32'h002, 32'h0,        16, 32'h9ABC1234, KD, 4'b1100, 32'h0,   32'h0,        32'h00009ABC));
      vecs.push_back(mk(1, 2'd0, 1, 32'h001, 32'h0,        1,  32'h11228344, KD, 4'b0010, 32'h0,   32'h0,        32'h00000083));
      vecs.push_back(mk(1, 2'd1, 0, 32'h010, 32'h0,        1,  32'h0000F00D, KD, 4'b0011, 32'h10,  32'h0,        32'hFFFFF00D));
      vecs.push_back(mk(1, 2'd2, 1, 32'h20C, 32'h0,        2,  32'hDEADBEEF, KD, 4'b1111, 32'h20C, 32'h0,        32'hDEADBEEF));
      vecs.push_back(mk(0, 2'd0, 0, 32'h402, 32'hFFFFFF5A, 1,  32'h55555555, KD, 4'b0100, 32'h400, 32'h5A5A5A5A, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'd2, 0, 32'h500, 32'h01234567, 1,  32'h0,        KD, 4'b1111, 32'h500, 32'h01234567, 32'hDEADBEEF));
      vecs.push_back(mk(1, 2'd1, 0, 32'h011, 32'h0,        0,  32'h0,        KM, 4'b0000, 32'h0,   32'h0,        32'hDEADBEEF));
      vecs.push_back(mk(1, 2'd0, 0, 32'h000, 32'h0,        1,  32'h0000007F, KD, 4'b0001, 32'h0,   32'h0,        32'h0000007F));

      foreach (vecs[i]) runVec(vecs[i]);

      // Reset on the second busy cycle, colliding with an ack.
      @(negedge iCLK);
      iValid = 1'b1; iRW = 1'b1; iSize = 2'd2; iUnsigned = 1'b0;
      iADDR = 32'h600; iWDATA = '0;
      #1 chk("rstseq_stall0", 32'(oStall), 32'd1);
      @(negedge iCLK);
      iValid = 1'b0;
      chk("rstseq_req1", 32'(dc.oDC_REQ), 32'd1);
      @(negedge iCLK);
      chk("rstseq_req2", 32'(dc.oDC_REQ), 32'd1);
      iRST = 1'b1;
      dc.iDC_ACK = 1'b1;
      dc.iDC_RDATA = 32'hAAAAAAAA;
      @(negedge iCLK);
      iRST = 1'b0;
      dc.iDC_ACK = 1'b0;
      chk("rstseq_req", 32'(dc.oDC_REQ), 32'd0);
      chk("rstseq_pulses", {29'd0, oDone, oMisalign, oBusErr}, 32'd0);
      chk("rstseq_stall", 32'(oStall), 32'd0);
      chk("rstseq_rdata", oRDATA, 32'h0);
      chk("rstseq_bus", {dc.oDC_ADDR[27:0], dc.oDC_BE}, 32'h0);
      chk("rstseq_wdata", dc.oDC_WDATA, 32'h0);
      chk("rstseq_we", 32'(dc.oDC_WE), 32'd0);

      runVec(mk(1, 2'd2, 0, 32'h604, 32'h0, 1, 32'h13579BDF, KD, 4'b1111, 32'h604, 32'h0, 32'h13579BDF));

      repeat (3) @(negedge iCLK);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/core_lsu_ctrl.md
CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: number of cycles oDC_REQ may stay high without iDC_ACK before a bus error; legal range 2..255.
REQ-002 iCLK  input  1  single clock; all state updates on rising edge.
REQ-003 iRST  input  1  synchronous, active-high reset.
REQ-004 iValid  input  1  load/store request from memory stage.
REQ-005 iRW  input  1  1 = read (load), 0 = write (store).
REQ-006 iSize  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 iUnsigned  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-008 iADDR  input  32  byte address.
REQ-009 iWDATA  input  32  store data, right-aligned.
REQ-010 oStall  output  1  hold pipeline.
REQ-011 oRDATA  output  32  extended load result.
REQ-012 oDone  output  1  one-cycle completion pulse.
REQ-013 oMisalign  output  1  one-cycle misaligned/illegal-size pulse.
REQ-014 oBusErr  output  1  one-cycle timeout pulse.
REQ-015 oDC_REQ, oDC_WE (1 each), oDC_BE (4), oDC_ADDR (32), oDC_WDATA (32)  outputs  DCache request bus.
REQ-016 iDC_ACK (1), iDC_RDATA (32)  inputs  DCache acknowledge and read data.

Function
REQ-017 States SHALL be IDLE, BUSY, DONE, ERR.
REQ-018 Aligned: byte always; half when iADDR[0]=0; word when iADDR[1:0]=00; iSize=11 never aligned.
REQ-019 IDLE with iValid and aligned: latch iRW, iSize, iUnsigned, iADDR, iWDATA; go BUSY; oStall=1 combinationally in that same cycle.
REQ-020 IDLE with iValid and not aligned: stay IDLE, no DCache request, oStall=0, oMisalign=1 in the next cycle only.
REQ-021 BUSY: oDC_REQ=1, all oDC_* outputs driven from latched values and stable until the ack cycle; oStall=1.
REQ-022 oDC_ADDR SHALL be {addr[31:2],2'b00}; oDC_WE = ~rw.
REQ-023 oDC_BE: byte 4'b0001<<addr[1:0]; half addr[1] ? 1100 : 0011; word 1111; reads use the same mask.
REQ-024 oDC_WDATA: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-025 BUSY with iDC_ACK: for reads, extract the addressed byte lane (addr[1:0]) or half lane (addr[1]) of iDC_RDATA, extend per iUnsigned, register into oRDATA; go DONE; oDC_REQ low from the next cycle.
REQ-026 Stores SHALL leave oRDATA unchanged.
REQ-027 Word loads ignore iUnsigned.
REQ-028 BUSY timer SHALL count cycles with oDC_REQ high; if TIMEOUT cycles elapse without ack, go ERR and drop oDC_REQ.
REQ-029 Ack in the final timeout cycle SHALL win (go DONE, no error).
REQ-030 DONE: oDone=1, oStall=0, iValid ignored; go IDLE next cycle.
REQ-031 ERR: oBusErr=1, oStall=0, oRDATA unchanged, iValid ignored; go IDLE next cycle.
REQ-032 iDC_ACK outside BUSY SHALL be ignored.
REQ-033 Latency: request at cycle 0, oDC_REQ high from cycle 1, ack at cycle k>=1, oDone/oRDATA valid at cycle k+1; oStall high cycles 0..k.
REQ-034 oDone, oMisalign and oBusErr SHALL be mutually exclusive.

Reset
REQ-035 iRST SHALL force IDLE, timer 0, and all outputs 0 (oRDATA=32'h0) in the following cycle.
REQ-036 iRST during BUSY SHALL drop oDC_REQ in the next cycle with no oDone or oBusErr pulse.
REQ-037 iRST has priority over iValid and iDC_ACK in the same cycle.

Verification
REQ-038 LB, iADDR=0x103, iUnsigned=0, ack one cycle after REQ, iDC_RDATA=0x80AABBCC -> oDC_BE=1000, oDC_ADDR=0x100, oRDATA=0xFFFFFF80, oDone at cycle 3, oStall high cycles 0..2.
REQ-039 SH, iADDR=0x202, iWDATA=0x0000BEEF, ack after 3 cycles -> oDC_WE=1, oDC_BE=1100, oDC_WDATA=0xBEEFBEEF, signals stable throughout BUSY, oDone once.
REQ-040 LW, iADDR=0x301 -> oMisalign pulse next cycle, oDC_REQ never high, oStall 0; iSize=11 -> same.
REQ-041 LHU, iADDR=0x002, no ack, TIMEOUT=16 -> oDC_REQ high exactly 16 cycles, oBusErr one pulse, oRDATA unchanged; repeat with ack on 16th cycle -> oDone, no oBusErr.
REQ-042 iRST asserted on 2nd BUSY cycle with ack arriving in the same cycle -> all outputs 0 next cycle, no oDone; new LW afterward completes normally.
